dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the number of clock edges from request acceptance to response (legal range 1..15).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low (rst=0 resets on the clock edge).
REQ-005 SHALL have port req_valid  input  1  MEM stage presents an access.
REQ-006 SHALL have port req_ready  output  1  responder can accept an access this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address (the ALU result).
REQ-009 SHALL have port req_wdata  input  32  store data (the rs2 value).
REQ-010 SHALL have port req_funct3  input  3  RISC-V load/store funct3.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-012 SHALL have port rsp_rdata  output  32  extended load data.
REQ-013 SHALL have port rsp_err  output  1  misaligned or illegal access, qualified by rsp_valid.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, RESP; req_ready=1 only in IDLE.
REQ-015 SHALL accept a request on an edge where state=IDLE and req_valid=1, latching we, addr, wdata and funct3 in the same edge.
REQ-016 SHALL ignore req_* inputs in BUSY and RESP, with no queuing of a second request.
REQ-017 SHALL assert rsp_valid for exactly one cycle, in the cycle that begins LATENCY edges after the accepting edge (LATENCY=1: IDLE->RESP directly; otherwise IDLE->BUSY, with a down-counter of 4 bits, then ->RESP).
REQ-018 SHALL leave RESP for IDLE unconditionally after one cycle, so req_ready=1 again in the following cycle; the back-to-back issue interval is LATENCY+1 cycles.
REQ-019 SHALL form the word index from addr[log2(DEPTH_WORDS)+1:2], ignoring higher bits (the address wraps modulo 4*DEPTH_WORDS bytes).
REQ-020 SHALL support loads with funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-021 SHALL select the byte lane for loads by addr[1:0] and the halfword lane by addr[1].
REQ-022 SHALL sign-extend LB/LH results and zero-extend LBU/LHU results.
REQ-023 SHALL support stores with funct3 000 SB, 001 SH, 010 SW, writing only the addressed lanes (SB: one lane = wdata[7:0]; SH: two lanes = wdata[15:0]) and preserving the other lanes.
REQ-024 SHALL commit stores on the same edge that enters RESP, and never earlier.
REQ-025 SHALL register load data on the edge entering RESP.
REQ-026 SHALL return the newly stored data to a load issued after a store to the same word.
REQ-027 SHALL set rsp_err=1 in RESP when any of the following holds: halfword with addr[0]=1; word with addr[1:0]!=0; load funct3 011/110/111; store funct3 other than 000/001/010.
REQ-028 SHALL, on error, suppress the write and drive rsp_rdata=0.
REQ-029 SHALL drive rsp_rdata=0 for store responses.
REQ-030 SHALL hold rsp_rdata and rsp_err at their last response values outside RESP.

Reset
REQ-031 SHALL, when rst=0 on an edge, set state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0, with req_ready=1 from the next cycle.
REQ-032 SHALL, on reset in BUSY, abandon the pending access with no memory write and no rsp_valid.
REQ-033 SHALL NOT clear storage contents on reset; contents are undefined until written.

Verification
REQ-034 SHALL pass this scenario: SW addr 0x20, wdata 0xABCD1234, then LW addr 0x20 -> rsp_valid exactly 2 edges after each accept; load rsp_rdata=0xABCD1234, rsp_err=0.
REQ-035 SHALL pass this scenario: after REQ-034, LB 0x23 -> 0xFFFFFFAB; LBU 0x23 -> 0x000000AB; LH 0x20 -> 0x00001234; LHU 0x22 -> 0x0000ABCD.
REQ-036 SHALL pass this scenario: SB 0x21 wdata 0x000000EE, then LW 0x20 -> 0xABCDEE34; SH 0x22 wdata 0x00008001, then LW 0x20 -> 0x8001EE34.
REQ-037 SHALL pass this scenario: LW 0x22 and SH 0x21 wdata 0x5555 -> rsp_err=1, rsp_rdata=0; a following LW 0x20 -> 0x8001EE34 (word unchanged).
REQ-038 SHALL pass this scenario: req_valid held high continuously -> req_ready high 1 cycle in every 3, exactly one rsp_valid per accept, extra requests not accepted; SW to 0x420 with DEPTH_WORDS=256 -> LW 0x20 returns the 0x420 data (wrap).
REQ-039 SHALL pass this scenario: SW 0x40 accepted, rst=0 on the next edge, then LW 0x40 -> no rsp_valid for the aborted store; the load returns the prior contents of 0x40, not the store data.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port data-memory responder for a RISC-V MEM stage: one access in flight,
// fixed response latency, byte/halfword/word loads and stores with misalignment detection.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [3:0]    r_cnt;
   logic [3:0]    w_cnt_next;

   logic          r_we;
   logic [AW+1:0] r_addr;
   logic [31:0]   r_wdata;
   logic [2:0]    r_funct3;

   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          r_req_ready;
   logic          r_rsp_valid;
   logic [31:0]   r_rdata;
   logic          r_err;

   logic          w_we;
   logic [AW+1:0] w_addr;
   logic [31:0]   w_wdata;
   logic [2:0]    w_funct3;
   logic [31:0]   w_word;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_load;
   logic [31:0]   w_store_data;
   logic [31:0]   w_merged;
   logic [3:0]    w_be;
   logic          w_err;
   logic          w_accept;
   logic          w_enter_resp;
   logic          w_commit;
   logic          w_unused_addr;

   assign w_unused_addr = ^req_addr[31:AW+2];
   assign w_accept      = (r_state == IDLE) && req_valid;
   assign w_enter_resp  = (w_next == RESP);
   assign w_commit      = w_enter_resp && w_we && !w_err;

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

   // With LATENCY=1 the access resolves on its own accepting edge, so decode the live request
   always_comb begin
      if (r_state == IDLE) begin
         w_we     = req_we;
         w_addr   = req_addr[AW+1:0];
         w_wdata  = req_wdata;
         w_funct3 = req_funct3;
      end else begin
         w_we     = r_we;
         w_addr   = r_addr;
         w_wdata  = r_wdata;
         w_funct3 = r_funct3;
      end
   end

   // Next-state and latency down-counter
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               if (LATENCY == 1) begin
                  w_next = RESP;
               end else begin
                  w_next     = BUSY;
                  w_cnt_next = 4'(LATENCY - 2);
               end
            end else begin
               w_next = IDLE;
            end
         end
         BUSY: begin
            if (r_cnt == 4'd0) begin
               w_next = RESP;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_word = r_mem[w_addr[AW+1:2]];
   assign w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
   assign w_half = w_word[{w_addr[1], 4'b0000} +: 16];

   // Lane decode, alignment/funct3 error detection, load extension
   always_comb begin
      w_err        = 1'b0;
      w_load       = 32'd0;
      w_be         = 4'b0000;
      w_store_data = 32'd0;
      if (w_we) begin
         case (w_funct3)
            3'b000: begin
               w_be         = 4'b0001 << w_addr[1:0];
               w_store_data = {4{w_wdata[7:0]}};
            end
            3'b001: begin
               if (w_addr[0]) begin
                  w_err = 1'b1;
               end else begin
                  w_be         = 4'b0011 << {w_addr[1], 1'b0};
                  w_store_data = {2{w_wdata[15:0]}};
               end
            end
            3'b010: begin
               if (w_addr[1:0] != 2'b00) begin
                  w_err = 1'b1;
               end else begin
                  w_be         = 4'b1111;
                  w_store_data = w_wdata;
               end
            end
            default: w_err = 1'b1;
         endcase
      end else begin
         case (w_funct3)
            3'b000: w_load = {{24{w_byte[7]}}, w_byte};
            3'b001: begin
               if (w_addr[0]) begin
                  w_err = 1'b1;
               end else begin
                  w_load = {{16{w_half[15]}}, w_half};
               end
            end
            3'b010: begin
               if (w_addr[1:0] != 2'b00) begin
                  w_err = 1'b1;
               end else begin
                  w_load = w_word;
               end
            end
            3'b100: w_load = {24'd0, w_byte};
            3'b101: begin
               if (w_addr[0]) begin
                  w_err = 1'b1;
               end else begin
                  w_load = {16'd0, w_half};
               end
            end
            default: w_err = 1'b1;
         endcase
      end
   end

   // Read-modify-write merge keeps unaddressed lanes intact
   always_comb begin
      w_merged = w_word;
      for (int i = 0; i < 4; i++) begin
         if (w_be[i]) begin
            w_merged[8*i +: 8] = w_store_data[8*i +: 8];
         end else begin
            w_merged[8*i +: 8] = w_word[8*i +: 8];
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Request capture on acceptance
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= 32'd0;
         r_funct3 <= 3'd0;
      end else if (w_accept) begin
         r_we     <= req_we;
         r_addr   <= req_addr[AW+1:0];
         r_wdata  <= req_wdata;
         r_funct3 <= req_funct3;
      end
   end

   // Response outputs; data and error hold between responses
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rdata     <= 32'd0;
         r_err       <= 1'b0;
      end else begin
         r_req_ready <= (w_next == IDLE);
         r_rsp_valid <= w_enter_resp;
         if (w_enter_resp) begin
            r_rdata <= (w_we || w_err) ? 32'd0 : w_load;
            r_err   <= w_err;
         end
      end
   end

   // Storage is never cleared; a reset edge blocks the commit of a pending store
   always_ff @(posedge clk) begin
      if (rst && w_commit) begin
         r_mem[w_addr[AW+1:2]] <= w_merged;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (default parameters): scoreboard of expected
// responses, latency/pulse-width checks, throughput, address wrap and reset abort.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic issue(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rdata, input logic exp_err);
      int   n;
      exp_t e;
      @(negedge clk);
      req_we     = we;
      req_addr   = addr;
      req_wdata  = wdata;
      req_funct3 = f3;
      req_valid  = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_timeout: req_ready=%b required 1", name, req_ready);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      exp_q.push_back('{rdata: exp_rdata, err: exp_err});
      #1 req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rsp_valid !== 1'b1 && n < 20);
      e = exp_q.pop_front();
      checks++;
      if (rsp_valid !== 1'b1 || n != 2) begin
         errors++;
         $display("FAIL %s latency: edges=%0d rsp_valid=%b required 2 edges", name, n, rsp_valid);
      end
      if (rsp_valid === 1'b1) begin
         checks++;
         if (rsp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL %s rdata: got %h required %h", name, rsp_rdata, e.rdata);
         end
         checks++;
         if (rsp_err !== e.err) begin
            errors++;
            $display("FAIL %s err: got %b required %b", name, rsp_err, e.err);
         end
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_width: rsp_valid=%b required 0", name, rsp_valid);
         end
      end
   endtask

   task automatic test_reset();
      rst        = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      req_funct3 = 3'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid);
      end
      checks++;
      if (rsp_rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_rdata: got %h required 00000000", rsp_rdata);
      end
      checks++;
      if (rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_err: got %b required 0", rsp_err);
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b required 1", req_ready);
      end
      rst = 1'b1;
   endtask

   task automatic test_word();
      issue("sw_20", 1'b1, 32'h20, 32'hABCD1234, 3'b010, 32'd0, 1'b0);
      issue("lw_20", 1'b0, 32'h20, 32'd0,        3'b010, 32'hABCD1234, 1'b0);
   endtask

   task automatic test_subword_loads();
      issue("lb_23",  1'b0, 32'h23, 32'd0, 3'b000, 32'hFFFFFFAB, 1'b0);
      issue("lbu_23", 1'b0, 32'h23, 32'd0, 3'b100, 32'h000000AB, 1'b0);
      issue("lh_20",  1'b0, 32'h20, 32'd0, 3'b001, 32'h00001234, 1'b0);
      issue("lhu_22", 1'b0, 32'h22, 32'd0, 3'b101, 32'h0000ABCD, 1'b0);
      issue("lb_20",  1'b0, 32'h20, 32'd0, 3'b000, 32'h00000034, 1'b0);
   endtask

   task automatic test_partial_stores();
      issue("sb_21",   1'b1, 32'h21, 32'h000000EE, 3'b000, 32'd0, 1'b0);
      issue("lw_sb",   1'b0, 32'h20, 32'd0,        3'b010, 32'hABCDEE34, 1'b0);
      issue("sh_22",   1'b1, 32'h22, 32'h00008001, 3'b001, 32'd0, 1'b0);
      issue("lw_sh",   1'b0, 32'h20, 32'd0,        3'b010, 32'h8001EE34, 1'b0);
      issue("lh_22",   1'b0, 32'h22, 32'd0,        3'b001, 32'hFFFF8001, 1'b0);
   endtask

   task automatic test_errors();
      issue("lw_22_mis",  1'b0, 32'h22, 32'd0,        3'b010, 32'd0, 1'b1);
      issue("sh_21_mis",  1'b1, 32'h21, 32'h00005555, 3'b001, 32'd0, 1'b1);
      issue("ld_f3_011",  1'b0, 32'h20, 32'd0,        3'b011, 32'd0, 1'b1);
      issue("st_f3_100",  1'b1, 32'h20, 32'h77777777, 3'b100, 32'd0, 1'b1);
      issue("lw_unchg",   1'b0, 32'h20, 32'd0,        3'b010, 32'h8001EE34, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (rsp_rdata !== 32'h8001EE34 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL hold: got rdata=%h err=%b required 8001ee34 0", rsp_rdata, rsp_err);
      end
   endtask

   task automatic test_back_to_back();
      int rdy = 0;
      int rsp = 0;
      @(negedge clk);
      req_we     = 1'b0;
      req_addr   = 32'h20;
      req_wdata  = 32'd0;
      req_funct3 = 3'b010;
      req_valid  = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if (req_ready !== ((i % 3) == 0)) begin
            errors++;
            $display("FAIL b2b_ready cycle %0d: got %b required %b", i, req_ready, (i % 3) == 0);
         end
         checks++;
         if (rsp_valid !== ((i % 3) == 2)) begin
            errors++;
            $display("FAIL b2b_rsp cycle %0d: got %b required %b", i, rsp_valid, (i % 3) == 2);
         end
         if (req_ready === 1'b1) rdy++;
         if (rsp_valid === 1'b1) begin
            rsp++;
            checks++;
            if (rsp_rdata !== 32'h8001EE34) begin
               errors++;
               $display("FAIL b2b_rdata cycle %0d: got %h required 8001ee34", i, rsp_rdata);
            end
         end
      end
      req_valid = 1'b0;
      checks++;
      if (rdy != 4 || rsp != 4) begin
         errors++;
         $display("FAIL b2b_counts: accepts=%0d responses=%0d required 4 4", rdy, rsp);
      end
      @(negedge clk);
   endtask

   task automatic test_wrap();
      issue("sw_420", 1'b1, 32'h420, 32'h13572468, 3'b010, 32'd0, 1'b0);
      issue("lw_wrap", 1'b0, 32'h20, 32'd0,       3'b010, 32'h13572468, 1'b0);
   endtask

   task automatic test_reset_abort();
      issue("sw_40_prior", 1'b1, 32'h40, 32'h11111111, 3'b010, 32'd0, 1'b0);
      @(negedge clk);
      req_we     = 1'b1;
      req_addr   = 32'h40;
      req_wdata  = 32'hDEADBEEF;
      req_funct3 = 3'b010;
      req_valid  = 1'b1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_ready: got %b required 1", req_ready);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst       = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_rsp cycle %0d: got %b required 0", i, rsp_valid);
         end
      end
      issue("lw_40_after", 1'b0, 32'h40, 32'd0, 3'b010, 32'h11111111, 1'b0);
   endtask

   initial begin
      test_reset();
      test_word();
      test_subword_loads();
      test_partial_stores();
      test_errors();
      test_back_to_back();
      test_wrap();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
